// File: rtl/wptr_level_if.sv
// Write-side bundle of the async FIFO write-pointer block: client handshake,
// RAM write port, cross-domain pointers and fill-level/flag outputs.
interface wptr_level_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic                ovf_clr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE:0]   afull_thresh;
  logic                wen;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                wafull;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  modport master (
    output winc, ovf_clr, rptr, afull_thresh,
    input  wen, waddr, wptr, wfull, wafull, wlevel, wovf
  );

  modport slave (
    input  winc, ovf_clr, rptr, afull_thresh,
    output wen, waddr, wptr, wfull, wafull, wlevel, wovf
  );
endinterface

// File: rtl/wptr_level.sv
// Write-domain Gray pointer, rptr synchroniser, exact fill level and
// full / almost-full / sticky-overflow flags for the async FIFO.
module wptr_level #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        wclk,
  input  logic        wrst,
  wptr_level_if.slave bus
);
  localparam int A = ADDRSIZE;
  localparam logic [A:0] DEPTH = {1'b1, {A{1'b0}}};

  logic [A:0] wbin_q, wbin_d;
  logic [A:0] wptr_q, wptr_d;
  logic [A:0] wlevel_q, wlevel_d;
  logic       wfull_q, wfull_d;
  logic       wafull_q, wafull_d;
  logic       wovf_q, wovf_d;
  logic [A:0] sq_q [SYNC_STAGES];
  logic [A:0] sq_d [SYNC_STAGES];
  logic [A:0] rq;
  logic [A:0] rbin_s;
  logic       wen;

  always_comb begin
    rq     = sq_q[SYNC_STAGES-1];
    rbin_s = '0;
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    for (int i = 0; i <= A; i++) begin
      rbin_s[i] = ^(rq >> i);
    end

    wen      = bus.winc & ~wfull_q;
    wbin_d   = wbin_q + {{A{1'b0}}, wen};
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    wlevel_d = wbin_d - rbin_s;
    wfull_d  = (wlevel_d == DEPTH);
    wafull_d = (wlevel_d >= bus.afull_thresh);
    // A rejected write sets overflow even when a clear arrives in the same cycle
    wovf_d   = (bus.winc & wfull_q) | (wovf_q & ~bus.ovf_clr);

    sq_d[0] = bus.rptr;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sq_d[i] = sq_q[i-1];
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sq_q[i] <= '0;
      end
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sq_q[i] <= sq_d[i];
      end
    end
  end

  assign bus.wen    = wen;
  assign bus.waddr  = wbin_q[A-1:0];
  assign bus.wptr   = wptr_q;
  assign bus.wfull  = wfull_q;
  assign bus.wafull = wafull_q;
  assign bus.wlevel = wlevel_q;
  assign bus.wovf   = wovf_q;
endmodule

// File: tb/tb_wptr_level.sv
// Scoreboard bench for wptr_level: stimulus pushes expected results from a
// count-based FIFO model; a monitor pops and compares every cycle.
module tb_wptr_level;
  localparam int A     = 4;
  localparam int DEPTH = 16;
  localparam int SS    = 2;

  logic wclk = 1'b0;
  logic wrst;
  always #5 wclk = ~wclk;

  wptr_level_if #(.ADDRSIZE(A)) bus ();
  wptr_level #(.ADDRSIZE(A), .SYNC_STAGES(SS)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  typedef struct {
    bit rst;
    int wptr;
    int waddr;
    int wlevel;
    bit wfull;
    bit wafull;
    bit wovf;
  } exp_t;

  exp_t exp_q[$];
  bit   wen_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model: counts of words written and read; the write side sees the read
  // count as it stood SS edges ago.
  int rcnt   = 0;
  int thresh = 12;
  int m_wcnt = 0;
  int m_level = 0;
  bit m_full = 0, m_afull = 0, m_ovf = 0;
  int rhist[$];

  function automatic logic [A:0] gray(int n);
    logic [A:0] b;
    b = (A+1)'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(bit rst, bit winc, bit clr);
    exp_t e;
    int   rs;
    bit   acc;
    @(negedge wclk);
    wrst             = rst;
    bus.winc         = winc;
    bus.ovf_clr      = clr;
    bus.rptr         = gray(rcnt);
    bus.afull_thresh = (A+1)'(thresh);
    acc = winc & ~m_full;
    wen_q.push_back(acc);
    if (rst) begin
      m_wcnt = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
      rhist.delete();
      repeat (SS) rhist.push_back(0);
    end else begin
      m_ovf = (winc & m_full) | (m_ovf & ~clr);
      rs = rhist.pop_front();
      rhist.push_back(rcnt);
      m_wcnt  += int'(acc);
      m_level = m_wcnt - rs;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= thresh);
    end
    e.rst    = rst;
    e.wptr   = int'(gray(m_wcnt));
    e.waddr  = m_wcnt % DEPTH;
    e.wlevel = m_level;
    e.wfull  = m_full;
    e.wafull = m_afull;
    e.wovf   = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge wclk);
    #2;
  endtask

  // Monitor
  initial begin
    exp_t       e;
    logic [A:0] prev = '0;
    forever begin
      @(negedge wclk);
      #1;
      if (wen_q.size() > 0) check("wen", int'(bus.wen), int'(wen_q.pop_front()));
      @(posedge wclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wptr",   int'(bus.wptr),   e.wptr);
        check("waddr",  int'(bus.waddr),  e.waddr);
        check("wlevel", int'(bus.wlevel), e.wlevel);
        check("wfull",  int'(bus.wfull),  int'(e.wfull));
        check("wafull", int'(bus.wafull), int'(e.wafull));
        check("wovf",   int'(bus.wovf),   int'(e.wovf));
        if (!e.rst) check("wptr_one_bit", int'($countones(bus.wptr ^ prev) <= 1), 1);
        prev = bus.wptr;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (SS) rhist.push_back(0);
    bus.winc = 1'b0; bus.ovf_clr = 1'b0; bus.rptr = '0; bus.afull_thresh = '0;
    wrst = 1'b1;

    // Reset, then fill with threshold 12
    rcnt = 0; thresh = 12;
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    after_edge();
    check("full_after_16", int'(bus.wfull), 1);
    check("level_after_16", int'(bus.wlevel), 16);
    step(0, 1, 0);
    after_edge();
    check("wptr_held_full", int'(bus.wptr), 5'b11000);
    check("ovf_after_17", int'(bus.wovf), 1);

    // Set beats clear, then clear alone
    step(0, 1, 1);
    step(0, 0, 1);
    step(0, 0, 0);

    // Drain by four reads; level follows 3 edges later
    for (int i = 0; i < 4; i++) begin
      rcnt++;
      step(0, 0, 0);
    end
    repeat (5) step(0, 0, 0);

    // Threshold 0 while empty, then threshold above depth while filling
    rcnt = 0; thresh = 0;
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    thresh = 17;
    for (int i = 0; i < 18; i++) step(0, 1, 0);

    // Threshold equal to depth tracks full
    thresh = 16;
    repeat (2) step(0, 0, 0);

    // Wrap-around with reads trailing
    rcnt = 0; thresh = 12;
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      if (rcnt < m_wcnt - 1) rcnt++;
      step(0, 1, 0);
    end
    repeat (4) step(0, 0, 0);

    // Reset mid-fill with a write request present
    rcnt = 0;
    step(1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0);
    step(1, 1, 0);
    after_edge();
    check("waddr_after_rst", int'(bus.waddr), 0);
    check("level_after_rst", int'(bus.wlevel), 0);
    step(0, 1, 0);

    // Randomised traffic
    for (int i = 0; i < 700; i++) begin
      bit r, w, c;
      r = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 99) < 60);
      c = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) thresh = $urandom_range(0, 18);
      if (r) rcnt = 0;
      else if (rcnt < m_wcnt && $urandom_range(0, 99) < 45) rcnt++;
      step(r, w, c);
    end

    repeat (3) @(posedge wclk);
    #3;
    check("queues_drained", exp_q.size() + wen_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
